// File: rtl/device_id_user_register.sv
// device_id_user_register: JTAG identification / user code data register.
//
// A WIDTH-bit capture/shift register serves both the IDCODE and the USERCODE
// instructions. A shift counter qualifies updates, so only a scan of exactly
// WIDTH bits can change the user code register.
//
// Build option: define USERCODE_REG_EN to include the writable user code
// register. Without it, sel_usercode and updateDR are ignored, capture always
// loads IDCODE, and usercode is tied to USERCODE_INIT.
//
// The IDCODE default comes from the DEVICE_ID macro. If DEVICE_ID is not
// defined, it defaults to 32'h1234_5679.

`ifndef DEVICE_ID
`define DEVICE_ID 32'h1234_5679
`endif

module device_id_user_register #(
  parameter int unsigned      WIDTH         = 32,
  parameter logic [WIDTH-1:0] IDCODE        = `DEVICE_ID,
  parameter logic [WIDTH-1:0] USERCODE_INIT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             tck,
  input  logic             trst,
  input  logic             tdi,
  input  logic             captureDR,
  input  logic             shiftDR,
  input  logic             updateDR,
  input  logic             sel_usercode,
  output logic             tdo,
  output logic [WIDTH-1:0] usercode,
  output logic             shift_len_ok
);

  // Counter must be able to represent 0..WIDTH+1.
  localparam int unsigned    CntW    = $clog2(WIDTH + 2);
  localparam logic [CntW-1:0] CntFull = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntSat  = CntW'(WIDTH + 1);

  // Elaboration-time parameter sanity checks.
  if (IDCODE[0] != 1'b1) begin : g_idcode_lsb_check
    $error("IDCODE bit 0 must be 1 (IEEE 1149.1 12.1.1)");
  end

  if ((WIDTH < 2) || (WIDTH > 64)) begin : g_width_check
    $error("WIDTH must be in the range 2..64");
  end

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             len_ok_q, len_ok_d;
  logic [WIDTH-1:0] capture_val;
  logic             sel_eff;

`ifdef USERCODE_REG_EN

  logic [WIDTH-1:0] usercode_q, usercode_d;

  assign sel_eff = sel_usercode;

  // Capture source follows the active instruction.
  always_comb begin
    capture_val = sel_usercode ? usercode_q : IDCODE;
  end

  // Update commits the pre-edge shift register contents. It only does so for
  // a full-length scan under USERCODE.
  always_comb begin
    usercode_d = usercode_q;
    if (updateDR && sel_usercode && (cnt_q == CntFull)) begin
      usercode_d = sr_q;
    end
  end

  // User code register; reset abandons any scan in progress.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      usercode_q <= USERCODE_INIT;
    end else begin
      usercode_q <= usercode_d;
    end
  end

  assign usercode = usercode_q;

`else

  // Without the user code register, IDCODE is the only capture source.
  assign sel_eff     = 1'b0;
  assign capture_val = IDCODE;
  assign usercode    = USERCODE_INIT;

  logic unused_inputs;
  assign unused_inputs = sel_usercode ^ updateDR;

`endif

  // Shift register and shift counter next state; capture wins over shift.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (captureDR) begin
      sr_d  = capture_val;
      cnt_d = '0;
    end else if (shiftDR) begin
      sr_d = {tdi, sr_q[WIDTH-1:1]};
      if (cnt_q != CntSat) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Length flag is decoded from the next counter value and then registered.
  always_comb begin
    len_ok_d = (cnt_d == CntFull);
  end

  // Shift register, counter and length flag state.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      len_ok_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      len_ok_q <= len_ok_d;
    end
  end

  assign tdo          = sr_q[0];
  assign shift_len_ok = len_ok_q;

  // An IDCODE capture must always present a 1 on tdo first.
  property p_idcode_lsb;
    @(posedge tck) disable iff (!trst) (captureDR && !sel_eff) |=> tdo;
  endproperty

  a_idcode_lsb: assert property (p_idcode_lsb);

endmodule

// File: doc/device_id_user_register.md
DEVICE_ID_USER_REGISTER -- requirements
Module: device_id_user_register

Interface
REQ-001 Parameter WIDTH, default 32, meaning length in bits of the identification/user data register (legal range 2..64).
REQ-002 Parameter IDCODE, default `DEVICE_ID, meaning the WIDTH-bit identification value captured when sel_usercode is low.
REQ-003 Parameter USERCODE_INIT, default 1, meaning the WIDTH-bit reset value of the user code register.
REQ-004 Port tck  input  1  test clock; all state changes on its rising edge.
REQ-005 Port trst  input  1  test reset, asynchronous, active-low.
REQ-006 Port tdi  input  1  serial data in, enters at bit WIDTH-1.
REQ-007 Port captureDR  input  1  capture strobe (TAP Capture-DR state, register selected).
REQ-008 Port shiftDR  input  1  shift strobe (TAP Shift-DR state, register selected).
REQ-009 Port updateDR  input  1  update strobe (TAP Update-DR state, register selected).
REQ-010 Port sel_usercode  input  1  1 = USERCODE instruction active, 0 = IDCODE.
REQ-011 Port tdo  output  1  serial data out, combinational from shift register bit 0.
REQ-012 Port usercode  output  WIDTH  current user code register contents.
REQ-013 Port shift_len_ok  output  1  high when exactly WIDTH shifts occurred since last capture.

Function
REQ-014 Shift register of WIDTH bits; tdo SHALL equal bit 0 at all times.
REQ-015 captureDR high: shift register SHALL load IDCODE if sel_usercode=0, else usercode, next edge.
REQ-016 shiftDR high and captureDR low: shift register SHALL shift right one bit, tdi into bit WIDTH-1, bit 0 discarded.
REQ-017 captureDR and shiftDR both high: capture SHALL take priority; no shift.
REQ-018 Neither strobe high: shift register SHALL hold.
REQ-019 Shift counter, width clog2(WIDTH+2): cleared to 0 on capture, +1 per shift, saturating at WIDTH+1.
REQ-020 shift_len_ok SHALL be high exactly when counter == WIDTH; registered, no combinational path from strobes.
REQ-021 updateDR high with sel_usercode=1 and counter == WIDTH: usercode SHALL load the pre-edge shift register contents next edge.
REQ-022 updateDR with counter != WIDTH (short or over-length scan) SHALL leave usercode unchanged.
REQ-023 updateDR with sel_usercode=0 SHALL leave usercode unchanged (IDCODE is read-only).
REQ-024 updateDR simultaneous with captureDR or shiftDR: update SHALL use pre-edge shift register value; capture/shift act normally in the same edge.
REQ-025 Elaboration SHALL fail with an error if IDCODE bit 0 is not 1 (IEEE 1149.1 12.1.1).
REQ-026 An assertion SHALL flag any capture with sel_usercode=0 after which tdo != 1.

Reset
REQ-027 trst low SHALL immediately and asynchronously clear shift register to 0 (tdo=0), counter to 0 (shift_len_ok=0) and set usercode to USERCODE_INIT.
REQ-028 trst low mid-scan SHALL abandon the scan; no partial update ever reaches usercode.
REQ-029 Deassertion of trst SHALL take effect at the next tck rising edge with no extra latency.

Configuration
REQ-030 Macro USERCODE_REG_EN defined: user code register, sel_usercode and update logic present per REQ-015..REQ-024.
REQ-031 USERCODE_REG_EN undefined: sel_usercode and updateDR ignored, capture always loads IDCODE, usercode output tied to USERCODE_INIT, no update flops; counter and shift_len_ok retained.

Verification
REQ-032 WIDTH=32, IDCODE=32'h1234_5679, capture then 32 shifts tdi=0 -> tdo LSB-first 1,0,0,1,1,1,1,0,...; shift_len_ok high after 32nd shift.
REQ-033 sel_usercode=1, capture, shift 32 bits of 32'hA5A5_0001, update -> usercode=32'hA5A5_0001; recapture -> tdo sequence 1,0,0,0,... matches.
REQ-034 Same as REQ-033 but 31 shifts (and separately 33 shifts) then update -> usercode unchanged at USERCODE_INIT, shift_len_ok low.
REQ-035 trst pulsed low after 16 USERCODE shifts, then update -> usercode=USERCODE_INIT, tdo=0, shift_len_ok=0.
REQ-036 captureDR and shiftDR high together with sel_usercode=0 -> shift register = IDCODE, counter=0, tdo=1.
REQ-037 Build without USERCODE_REG_EN, sel_usercode=1, capture, 32 shifts -> tdo streams IDCODE; full update leaves usercode at USERCODE_INIT.
